ps2_host_tx: RTL and testbench

//   PS/2 host-to-device transmitter: sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) to the mouse.

---
 rtl/ps2_host_tx_if.sv | 30 +++
 rtl/ps2_host_tx.sv | 196 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx_if
//  Description : Command handshake and status bundle for the PS/2 host
//                transmitter. The master side offers a byte (tx_data and
//                tx_valid). The slave side (the transmitter) returns
//                tx_ready and the frame status: busy, done, ack_ok and
//                err_timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       err_timeout;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, ack_ok, err_timeout
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, ack_ok, err_timeout
    );
endinterface
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device transmitter. Sends one command byte to
//                the device as an 11-bit frame: start, 8 data bits LSB
//                first, odd parity, stop. It then samples the device ack.
//                Only open-drain enables are driven. The top level builds
//                PS2Clk = ps2_clk_oe ? 0 : z, and likewise for PS2Data.
//  Ports       : clock        - system clock
//                rst          - synchronous active-high reset
//                bus          - slave side: tx_data, tx_valid, tx_ready,
//                               busy, done, ack_ok, err_timeout
//                ps2_clk_i    - PS2Clk line level (asynchronous)
//                ps2_data_i   - PS2Data line level (asynchronous)
//                ps2_clk_oe   - 1 pulls PS2Clk low
//                ps2_data_oe  - 1 pulls PS2Data low
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10_000,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int FILTER_LEN     = 8
) (
    input  wire          clock,
    input  wire          rst,
    ps2_host_tx_if.slave bus,
    input  wire          ps2_clk_i,
    input  wire          ps2_data_i,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    localparam int c_inh_w = $clog2(INHIBIT_CYCLES + 1);
    localparam int c_to_w  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int c_flt_w = $clog2(FILTER_LEN + 1);

    // The inhibit phase lasts one cycle less than INHIBIT_CYCLES. The RTS
    // cycle that follows also holds the clock low, so the clock is held low
    // for exactly INHIBIT_CYCLES cycles in total.
    localparam logic [c_inh_w-1:0] c_inh_last = c_inh_w'(INHIBIT_CYCLES - 2);
    localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_flt_w-1:0] c_flt_last = c_flt_w'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_RTS       = 3'd2,
        S_SEND      = 3'd3,
        S_ACK       = 3'd4,
        S_WAIT_IDLE = 3'd5
    } state_t;

    state_t             r_state;
    logic               r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic               r_clk_filt;
    logic [c_flt_w-1:0] r_flt_cnt;
    logic               r_fall;
    logic [7:0]         r_byte;
    logic               r_par;
    logic [c_inh_w-1:0] r_inh_cnt;
    logic [c_to_w-1:0]  r_to_cnt;
    logic [3:0]         r_bit_idx;
    logic               r_ack_next;
    logic               r_clk_oe, r_data_oe, r_busy, r_done, r_ack_ok, r_err;

    // Synchronisers and glitch filter. The filtered level only moves after
    // FILTER_LEN consecutive samples that differ from it. r_fall is a
    // one-cycle strobe on each filtered 1->0 transition. The synchronisers
    // reset to 1, which is the idle level of both lines.
    always_ff @(posedge clock) begin
        if (rst) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
            r_clk_filt <= 1'b1;
            r_flt_cnt  <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_clk_s1 <= ps2_clk_i;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data_i;
            r_dat_s2 <= r_dat_s1;
            r_fall   <= 1'b0;
            if (r_clk_s2 == r_clk_filt) begin
                r_flt_cnt <= '0;
            end else if (r_flt_cnt == c_flt_last) begin
                r_clk_filt <= r_clk_s2;
                r_flt_cnt  <= '0;
                r_fall     <= r_clk_filt;
            end else begin
                r_flt_cnt <= r_flt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_byte     <= '0;
            r_par      <= 1'b0;
            r_inh_cnt  <= '0;
            r_to_cnt   <= '0;
            r_bit_idx  <= '0;
            r_ack_next <= 1'b0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ack_ok   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.tx_valid) begin
                        r_byte    <= bus.tx_data;
                        r_par     <= ~^bus.tx_data;
                        r_busy    <= 1'b1;
                        r_ack_ok  <= 1'b0;
                        r_clk_oe  <= 1'b1;
                        r_inh_cnt <= '0;
                        r_state   <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_inh_cnt == c_inh_last) begin
                        r_data_oe <= 1'b1;
                        r_state   <= S_RTS;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                    end
                end
                S_RTS: begin
                    // Release the clock and keep the start bit driven. The
                    // device now owns the clock.
                    r_clk_oe  <= 1'b0;
                    r_to_cnt  <= '0;
                    r_bit_idx <= '0;
                    r_state   <= S_SEND;
                end
                S_SEND, S_ACK, S_WAIT_IDLE: begin
                    // Completion is checked before the timeout, so a
                    // completion on the final timeout cycle still counts
                    // as done.
                    if (r_state == S_WAIT_IDLE && r_clk_filt && r_dat_s2) begin
                        r_done    <= 1'b1;
                        r_ack_ok  <= r_ack_next;
                        r_busy    <= 1'b0;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (r_to_cnt == c_to_last) begin
                        r_err     <= 1'b1;
                        r_busy    <= 1'b0;
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        if (r_fall) begin
                            if (r_state == S_SEND) begin
                                if (r_bit_idx < 4'd8) begin
                                    r_data_oe <= ~r_byte[r_bit_idx[2:0]];
                                end else if (r_bit_idx == 4'd8) begin
                                    r_data_oe <= ~r_par;
                                end else begin
                                    r_data_oe <= 1'b0;
                                end
                                r_bit_idx <= r_bit_idx + 1'b1;
                                if (r_bit_idx == 4'd9) begin
                                    r_state <= S_ACK;
                                end
                            end else if (r_state == S_ACK) begin
                                r_ack_next <= ~r_dat_s2;
                                r_state    <= S_WAIT_IDLE;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.tx_ready    = (r_state == S_IDLE);
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.ack_ok      = r_ack_ok;
    assign bus.err_timeout = r_err;
    assign ps2_clk_oe      = r_clk_oe;
    assign ps2_data_oe     = r_data_oe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Self-checking bench for ps2_host_tx. It includes a PS/2
//                device model that clocks at 1/400 of the system clock and
//                a behavioural reference model of the host-side outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int TO   = 20_000;
    localparam int HALF = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_host_tx_if bus ();
    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low = 1'b0, dev_data_low = 1'b0, glitch = 1'b0;
    logic clk_line, data_line;
    assign clk_line  = !(ps2_clk_oe || dev_clk_low || glitch);
    assign data_line = !(ps2_data_oe || dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_LEN    (4)
    ) dut (
        .clock      (clk),
        .rst        (rst),
        .bus        (bus),
        .ps2_clk_i  (clk_line),
        .ps2_data_i (data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected 11-bit frame, first bit on the wire in bit 0.
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        int          ones;
        logic [10:0] f;
        ones = 0;
        f    = '0;
        for (int i = 0; i < 8; i++) begin
            f[i+1] = b[i];
            ones  += int'(b[i]);
        end
        f[9]  = ((ones % 2) == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    bit m_idle = 1'b1, m_ack_ok = 1'b0, m_exp_ack = 1'b0, m_silent = 1'b0;
    bit pend_acc = 1'b0, rst_q = 1'b0, err_exp = 1'b0;
    bit prev_clk_oe = 1'b0, rel_on = 1'b0;
    int m_since = 0, n_done = 0, n_err = 0;
    int inh_run = 0, last_inh = 0, rel_cnt = 0, last_to = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_q) begin
                m_idle = 1'b1; m_ack_ok = 1'b0; pend_acc = 1'b0; m_since = 0; rel_on = 1'b0;
                chk("rst_clk_oe",  ps2_clk_oe,      0);
                chk("rst_data_oe", ps2_data_oe,     0);
                chk("rst_ready",   bus.tx_ready,    1);
                chk("rst_busy",    bus.busy,        0);
                chk("rst_done",    bus.done,        0);
                chk("rst_err",     bus.err_timeout, 0);
                chk("rst_ack_ok",  bus.ack_ok,      0);
            end else begin
                if (pend_acc) begin
                    m_idle = 1'b0; m_since = 0; m_ack_ok = 1'b0; pend_acc = 1'b0;
                end
                if (!m_idle) m_since++;
                chk("done_err_excl", bus.done && bus.err_timeout, 0);
                if (bus.done) begin
                    n_done++;
                    rel_on = 1'b0;
                    chk("done_allowed", !m_idle && !m_silent && (m_since > INH + 1), 1);
                    chk("done_ack_ok", bus.ack_ok, m_exp_ack);
                    m_ack_ok = m_exp_ack;
                    m_idle   = 1'b1;
                end
                err_exp = !m_idle && m_silent && (m_since == INH + 1 + TO);
                if (bus.err_timeout) n_err++;
                chk("err_timeout", bus.err_timeout, err_exp);
                if (err_exp) m_idle = 1'b1;
                chk("tx_ready", bus.tx_ready, m_idle);
                chk("busy",     bus.busy,     !m_idle);
                chk("ack_ok",   bus.ack_ok,   m_ack_ok);
                chk("clk_oe",   ps2_clk_oe,   !m_idle && (m_since <= INH));
                if (m_idle || m_since < INH)
                    chk("data_oe_off", ps2_data_oe, 0);
                else if (m_since <= INH + 1 || m_silent)
                    chk("data_oe_start", ps2_data_oe, 1);
            end
            if (ps2_clk_oe) inh_run++;
            else begin
                if (inh_run != 0) last_inh = inh_run;
                inh_run = 0;
            end
            if (rel_on) rel_cnt++;
            if (prev_clk_oe && !ps2_clk_oe && !rst_q) begin
                rel_on = 1'b1; rel_cnt = 0;
            end
            if (bus.err_timeout) begin
                last_to = rel_cnt; rel_on = 1'b0;
            end
            prev_clk_oe = ps2_clk_oe;
            pend_acc    = !rst && m_idle && bus.tx_valid;
            rst_q       = rst;
        end
    end

    // ---------------- device model ----------------
    int          dev_k = -1;
    logic [10:0] last_got;

    task automatic device_frame(input bit ack, input int glitch_k,
                                output logic [10:0] bits, output bit ok);
        int n;
        dev_k = -1;
        ok    = 1'b0;
        bits  = '0;
        n     = 0;
        while (!(clk_line && !data_line) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) return;
        ok = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        bits[0] = data_line;
        for (int k = 0; k < 11; k++) begin
            dev_k = k;
            if (k == 10 && ack) begin
                dev_data_low = 1'b1;
                repeat (20) @(posedge clk);
                #1;
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(posedge clk);
            #1;
            dev_clk_low = 1'b0;
            if (k < 10) bits[k+1] = data_line;
            if (k == 10) dev_data_low = 1'b0;
            if (k == glitch_k) begin
                repeat (100) @(posedge clk);
                #1 glitch = 1'b1;
                repeat (3) @(posedge clk);
                #1 glitch = 1'b0;
                repeat (HALF - 103) @(posedge clk);
            end else begin
                repeat (HALF) @(posedge clk);
            end
            #1;
        end
        dev_k = -1;
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
    endtask

    // One full frame. pulse_at > 0 re-asserts tx_valid that many cycles
    // into the frame, while the block is busy.
    task automatic run_frame(input logic [7:0] b, input bit ack, input int gk, input int pulse_at);
        int          d0, e0, n;
        logic [10:0] got;
        bit          ok;
        d0 = n_done; e0 = n_err;
        m_exp_ack = ack; m_silent = 1'b0;
        send(b);
        fork
            device_frame(ack, gk, got, ok);
            begin
                if (pulse_at > 0) begin
                    repeat (pulse_at) @(posedge clk);
                    #1;
                    bus.tx_data  = ~b;
                    bus.tx_valid = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.tx_valid = 1'b0;
                end
            end
        join
        last_got = got;
        chk("frame_rts_seen", ok, 1);
        chk("frame_bits", got, frame_of(b));
        n = 0;
        while (n_done == d0 && n_err == e0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        chk("frame_done_count", n_done - d0, 1);
        chk("frame_err_count",  n_err - e0,  0);
        repeat (300) @(negedge clk);
        chk("frame_single", n_done - d0, 1);
        chk("frame_idle_after", bus.tx_ready, 1);
    endtask

    initial begin
        int          d0, e0, n;
        logic [10:0] got;
        bit          ok;
        bit          ack;
        logic [7:0]  b;

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ready",   bus.tx_ready,    1);
        chk("reset_busy",    bus.busy,        0);
        chk("reset_clk_oe",  ps2_clk_oe,      0);
        chk("reset_data_oe", ps2_data_oe,     0);
        chk("reset_done",    bus.done,        0);
        chk("reset_err",     bus.err_timeout, 0);

        // 0xF4 with ack: literal frame and inhibit length
        run_frame(8'hF4, 1'b1, -1, 0);
        chk("f4_frame_literal", last_got, 11'h5E8);
        chk("f4_inhibit_len", last_inh, INH);
        chk("f4_ack_ok", bus.ack_ok, 1);

        // 0xFF without ack: parity 1, ack_ok 0
        run_frame(8'hFF, 1'b0, -1, 0);
        chk("ff_parity", last_got[9], 1);
        chk("ff_ack_ok", bus.ack_ok, 0);

        // silent device: timeout
        d0 = n_done; e0 = n_err;
        m_silent = 1'b1;
        send(8'hF4);
        n = 0;
        while (n_err == e0 && n < 30000) begin
            @(posedge clk);
            n++;
        end
        chk("to_seen", n_err - e0, 1);
        @(negedge clk);
        chk("to_delay", last_to, TO);
        chk("to_no_done", n_done - d0, 0);
        chk("to_clk_oe", ps2_clk_oe, 0);
        chk("to_data_oe", ps2_data_oe, 0);
        chk("to_ready", bus.tx_ready, 1);
        m_silent = 1'b0;

        // glitch on the clock during bit 3
        run_frame(8'hA5, 1'b1, 3, 0);

        // reset during bit 4, then a fresh 0xF4
        d0 = n_done; e0 = n_err;
        m_exp_ack = 1'b0;
        send(8'hF4);
        fork
            device_frame(1'b0, -1, got, ok);
            begin
                n = 0;
                while (!(dev_k == 4 && dev_clk_low) && n < 20000) begin
                    @(posedge clk);
                    n++;
                end
                chk("rst_reach_bit4", n < 20000, 1);
                repeat (50) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1 rst = 1'b0;
                @(negedge clk);
                chk("midrst_clk_oe",  ps2_clk_oe,   0);
                chk("midrst_data_oe", ps2_data_oe,  0);
                chk("midrst_ready",   bus.tx_ready, 1);
            end
        join
        repeat (300) @(negedge clk);
        chk("midrst_no_done", n_done - d0, 0);
        chk("midrst_no_err",  n_err - e0,  0);
        run_frame(8'hF4, 1'b1, -1, 0);
        chk("post_rst_ack_ok", bus.ack_ok, 1);

        // tx_valid while busy is ignored
        run_frame(8'h3C, 1'b1, -1, 1500);

        // random bytes and random ack behaviour
        for (int i = 0; i < 3; i++) begin
            b   = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            run_frame(b, ack, -1, 0);
            chk("rand_ack_ok", bus.ack_ok, ack);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #(200_000 * 10);
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
